// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the elastic register pipeline.
// Imported by dff_pipe and dff_pipe_stage.
package dff_pipe_pkg;

    typedef int unsigned occ_width_t;

    // Replicated across WIDTH to form the default stage reset value.
    localparam logic DefaultResetBit = 1'b0;

    function automatic occ_width_t occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid flag plus data word.
// Loads whenever rdy is high; data is captured only for a valid upstream word.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{DefaultResetBit}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (rdy) begin
            v_d = up_valid;
            if (up_valid) begin
                d_d = up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a combinational occupancy count.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DefaultResetBit}}
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam occ_width_t OccW = occ_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];

    // Unrolled ready chain: a stage can load if any stage at or below it is
    // empty, or the consumer takes the last word.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            acc    = acc || !v[i];
            rdy[i] = acc;
        end
    end

    // Flush forces every stage to load an empty word, clearing v but not d.
    for (genvar i = 0; i < DEPTH; i++) begin : stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_src_in
            assign up_valid = in_valid && !flush;
            assign up_data  = in_data;
        end else begin : g_src_prev
            assign up_valid = v[i-1] && !flush;
            assign up_data  = d[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .up_valid (up_valid),
            .up_data  (up_data),
            .rdy      (rdy[i] || flush),
            .v        (v[i]),
            .d        (d[i])
        );
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OccW'(v[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed vector table on an 8x4 pipeline plus a random scoreboard sweep
// on a DEPTH=1 and a WIDTH=1 instance.
module tb_dff_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Main 8x4 instance
    logic       rstn, in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    // Sweep instances share control, have separate data
    logic       s_rstn, s_iv, s_fl, s_ordy;
    logic       a_ir, a_ov, b_ir, b_ov;
    logic [7:0] a_din, a_dout;
    logic       b_din, b_dout;
    logic       a_occ;
    logic [2:0] b_occ;

    dff_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rstn(s_rstn), .in_valid(s_iv), .in_ready(a_ir),
        .in_data(a_din), .flush(s_fl), .out_valid(a_ov),
        .out_ready(s_ordy), .out_data(a_dout), .occupancy(a_occ)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(4)) u_w1 (
        .clk(clk), .rstn(s_rstn), .in_valid(s_iv), .in_ready(b_ir),
        .in_data(b_din), .flush(s_fl), .out_valid(b_ov),
        .out_ready(s_ordy), .out_data(b_dout), .occupancy(b_occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rstn, iv;
        logic [7:0] din;
        logic       ordy, fl, chk;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        logic [2:0] e_occ;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic iv, input logic [7:0] din, input logic ordy,
                       input logic fl, input logic chk, input logic e_ir, input logic e_ov,
                       input logic [7:0] e_od, input logic [2:0] e_occ);
        vec_t t;
        t = '{r, iv, din, ordy, fl, chk, e_ir, e_ov, e_od, e_occ};
        vq.push_back(t);
    endtask

    logic [7:0] qa[$];
    logic       qb[$];

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        s_rstn = 1'b0; s_iv = 1'b0; s_fl = 1'b0; s_ordy = 1'b0; a_din = '0; b_din = 1'b0;

        // rstn iv din ordy fl chk | in_ready out_valid out_data occupancy (pre-edge)
        // Reset and stream
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0);
        add(1, 1, 8'h11, 1, 0, 1, 1, 0, 8'h00, 0);
        add(1, 1, 8'h22, 1, 0, 1, 1, 0, 8'h00, 1);
        add(1, 1, 8'h33, 1, 0, 1, 1, 0, 8'h00, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h11, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h22, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'h33, 1);
        // Fill under stall: 6 offered, 4 accepted
        add(1, 1, 8'hA1, 0, 0, 1, 1, 0, 8'h33, 0);
        add(1, 1, 8'hA2, 0, 0, 1, 1, 0, 8'h33, 1);
        add(1, 1, 8'hA3, 0, 0, 1, 1, 0, 8'h33, 2);
        add(1, 1, 8'hA4, 0, 0, 1, 1, 0, 8'h33, 3);
        add(1, 1, 8'hA5, 0, 0, 1, 0, 1, 8'hA1, 4);
        add(1, 1, 8'hA6, 0, 0, 1, 0, 1, 8'hA1, 4);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA1, 4);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA2, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA3, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA4, 1);
        // Bubble collapse: B0 then 3 stalled cycles, then B1 accepted at once
        add(1, 1, 8'hB0, 0, 0, 1, 1, 0, 8'hA4, 0);
        add(1, 0, 8'h00, 0, 0, 1, 1, 0, 8'hA4, 1);
        add(1, 0, 8'h00, 0, 0, 1, 1, 0, 8'hA4, 1);
        add(1, 0, 8'h00, 0, 0, 1, 1, 0, 8'hA4, 1);
        add(1, 1, 8'hB1, 0, 0, 1, 1, 1, 8'hB0, 1);
        add(1, 0, 8'h00, 0, 0, 1, 1, 1, 8'hB0, 2);
        // Flush at occupancy 3 with 0x55 offered
        add(1, 1, 8'hC0, 0, 0, 1, 1, 1, 8'hB0, 2);
        add(1, 1, 8'h55, 0, 1, 1, 0, 1, 8'hB0, 3);
        // Reset mid-operation at occupancy 2
        add(1, 1, 8'hD0, 0, 0, 1, 1, 0, 8'hB0, 0);
        add(1, 1, 8'hD1, 0, 0, 1, 1, 0, 8'hB0, 1);
        add(0, 0, 8'h00, 1, 0, 1, 1, 0, 8'hB0, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0);
        add(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0);
        add(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0);
        // Full with out_ready=1: simultaneous in/out keeps occupancy
        add(1, 1, 8'hE0, 0, 0, 1, 1, 0, 8'h00, 0);
        add(1, 1, 8'hE1, 0, 0, 1, 1, 0, 8'h00, 1);
        add(1, 1, 8'hE2, 0, 0, 1, 1, 0, 8'h00, 2);
        add(1, 1, 8'hE3, 0, 0, 1, 1, 0, 8'h00, 3);
        add(1, 1, 8'hE4, 1, 0, 1, 1, 1, 8'hE0, 4);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hE1, 4);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hE2, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hE3, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hE4, 1);
        add(1, 0, 8'h00, 1, 0, 1, 1, 0, 8'hE4, 0);

        foreach (vq[i]) begin
            rstn = vq[i].rstn; in_valid = vq[i].iv; in_data = vq[i].din;
            out_ready = vq[i].ordy; flush = vq[i].fl;
            #1;
            if (vq[i].chk) begin
                check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
                check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
                check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vq[i].e_od));
                check($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
            end
            @(posedge clk); #1;
        end

        // Random sweep against queue scoreboards
        s_rstn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        s_rstn = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            logic fire_in, fire_a, fire_b;
            s_iv   = (c < 1000) && ($urandom_range(0, 3) != 0);
            s_ordy = (c >= 1000) || ($urandom_range(0, 2) != 0);
            s_fl   = (c < 1000) && ($urandom_range(0, 40) == 0);
            a_din  = 8'($urandom);
            b_din  = 1'($urandom);
            #1;
            check("d1 in_ready", 32'(a_ir), 32'((!a_ov || s_ordy) && !s_fl));
            check("d1 occupancy", 32'(a_occ), 32'(qa.size()));
            check("w1 occupancy", 32'(b_occ), 32'(qb.size()));
            if (a_ov) check("d1 out_data", 32'(a_dout), (qa.size() > 0) ? 32'(qa[0]) : 32'hDEAD);
            if (b_ov) check("w1 out_data", 32'(b_dout), (qb.size() > 0) ? 32'(qb[0]) : 32'hDEAD);
            fire_in = s_iv && a_ir;
            fire_a  = a_ov && s_ordy;
            fire_b  = b_ov && s_ordy;
            if (fire_a) void'(qa.pop_front());
            if (fire_b) void'(qb.pop_front());
            if (s_fl) begin
                qa.delete();
                qb.delete();
            end
            if (fire_in) qa.push_back(a_din);
            if (s_iv && b_ir) qb.push_back(b_din);
            @(posedge clk); #1;
        end
        check("d1 drained", 32'(qa.size()), 32'd0);
        check("w1 drained", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
